// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory access unit.
// Covers the Funct3 size/sign encodings, the FSM state type and the byte-enable width.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte or halfword of a 32-bit word and sign- or zero-extends it.
// Purely combinational, so the forwarding path can reuse it.
module load_extend
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = 8'(word >> {offset, 3'b000});
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_BU:   data = {24'b0, lane_b};
            F3_HU:   data = {16'b0, lane_h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store engine: it turns MemRead/MemWrite into a req/ack bus transaction and stalls the pipeline until the access completes.
// It also flags illegal or misaligned accesses and bus timeouts.
//
// state | meaning
// IDLE  | waiting for an access; a legal one is latched and stalls at once
// WAIT  | MemReq held until MemAck or the timeout expires
// DONE  | one-cycle completion: Done=1, Stall=0, inputs ignored
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] RdData,
    output logic              Done,
    output logic              Stall,
    output logic              Fault,
    output logic              BusErr,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic [BE_W-1:0]   MemBe,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData
);

    localparam int CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int TO_INIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TO_INIT);

    state_t state, state_nx;

    logic              access, is_write, legal, aligned;
    logic              start, fault_c, timeout_hit;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] ext_data;

    logic              we_q, berr_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [BE_W-1:0]   be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rd_q;
    logic [CNT_W-1:0]  cnt_q;

    // When both MemRead and MemWrite are set, the access is treated as a store.
    always_comb begin
        access   = MemRead | MemWrite;
        is_write = MemWrite;
        case (Funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !is_write;
            default:          legal = 1'b0;
        endcase
        case (Funct3[1:0])
            2'b01:   aligned = !Addr[0];
            2'b10:   aligned = (Addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        be_c    = '1;
        wdata_c = '0;
        if (is_write) begin
            case (Funct3[1:0])
                2'b00: begin
                    be_c    = BE_W'(1) << Addr[1:0];
                    wdata_c = {4{WrData[7:0]}};
                end
                2'b01: begin
                    be_c    = Addr[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{WrData[15:0]}};
                end
                default: begin
                    be_c    = '1;
                    wdata_c = WrData;
                end
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        start       = 1'b0;
        fault_c     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (legal && aligned) begin
                        start    = 1'b1;
                        state_nx = WAIT;
                    end else begin
                        fault_c = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (MemAck) begin
                    state_nx = DONE;
                end else if (TIMEOUT != 0 && cnt_q == '0) begin
                    timeout_hit = 1'b1;
                    state_nx    = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    load_extend u_load_extend (
        .funct3 (f3_q),
        .offset (off_q),
        .word   (MemRData),
        .data   (ext_data)
    );

    // The timeout down-counter is loaded on entry to WAIT and expires in the TIMEOUT-th WAIT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            berr_q  <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                addr_q  <= {Addr[ADDR_W-1:2], 2'b00};
                we_q    <= is_write;
                be_q    <= be_c;
                wdata_q <= wdata_c;
                f3_q    <= Funct3;
                off_q   <= Addr[1:0];
                cnt_q   <= TO_LOAD;
                berr_q  <= 1'b0;
            end else if (state == WAIT) begin
                if (MemAck) begin
                    rd_q <= we_q ? '0 : ext_data;
                end else if (timeout_hit) begin
                    rd_q   <= '0;
                    berr_q <= 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        MemReq   = (state == WAIT);
        Done     = (state == DONE);
        Stall    = start || (state == WAIT);
        Fault    = fault_c;
        BusErr   = Done && berr_q;
        RdData   = Done ? rd_q : '0;
        MemWe    = we_q;
        MemAddr  = addr_q;
        MemWData = wdata_q;
        MemBe    = be_q;
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Testbench for dmem_access_unit: table vectors, hand-written reset/ack sequences and random transactions.
// All random traffic is checked against an arithmetic reference model.
module tb_dmem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, MemAck;
    logic [2:0]  Funct3;
    logic [31:0] Addr, WrData, MemRData;
    logic [31:0] RdData, MemAddr, MemWData;
    logic        Done, Stall, Fault, BusErr, MemReq, MemWe;
    logic [3:0]  MemBe;

    int n_checks = 0;
    int n_fail   = 0;
    string cur_tag = "";

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_k;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] rd_exp;
        logic        berr;
    } vec_t;

    vec_t tbl[$];

    dmem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .Addr(Addr), .WrData(WrData), .RdData(RdData),
        .Done(Done), .Stall(Stall), .Fault(Fault), .BusErr(BusErr),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemBe(MemBe), .MemAck(MemAck), .MemRData(MemRData)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h", cur_tag, name, act, exp);
        end
    endtask

    // Expected results from the access rules: size, legality, alignment, lane arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t   r = v;
        int     size, off;
        bit     legal;
        longint val;
        off = int'(v.addr[1:0]);
        case (v.f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        legal   = (size != 0) && (v.wr ? (v.f3[2] == 1'b0) : (v.f3[2] == 1'b0 || size < 4));
        r.fault = !(legal && (size == 0 || off % size == 0));
        r.be    = v.wr ? ((size == 4) ? 4'hF : 4'(((1 << size) - 1) << off)) : 4'hF;
        r.mwdata = (size == 1) ? v.wdata[7:0] * 32'h01010101 :
                   (size == 2) ? v.wdata[15:0] * 32'h00010001 : v.wdata;
        r.berr  = v.ack_k > TO;
        if (v.wr || r.berr) begin
            r.rd_exp = 32'h0;
        end else begin
            val = longint'({32'b0, v.rdata}) >> (8 * off);
            if (size < 4) begin
                val = val % (longint'(1) << (8 * size));
                if (!v.f3[2] && val >= (longint'(1) << (8 * size - 1)))
                    val = val - (longint'(1) << (8 * size));
            end
            r.rd_exp = 32'(val);
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        int stall_cnt, k_end;
        @(posedge clk); #1;
        MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3; Addr = v.addr; WrData = v.wdata;
        @(negedge clk);
        chk("fault", Fault, v.fault);
        chk("req0", MemReq, 0);
        if (v.fault) begin
            chk("fault_stall", Stall, 0);
            chk("fault_rd", RdData, 0);
            @(posedge clk); #1;
            MemRead = 0; MemWrite = 0;
            @(negedge clk);
            chk("fault_noreq", MemReq, 0);
            chk("fault_nodone", Done, 0);
            return;
        end
        stall_cnt = Stall ? 1 : 0;
        k_end = (v.ack_k > TO) ? TO : v.ack_k;
        for (int c = 1; c <= k_end; c++) begin
            @(posedge clk); #1;
            MemAck   = (c == v.ack_k);
            MemRData = (c == v.ack_k) ? v.rdata : $urandom;
            @(negedge clk);
            if (Stall) stall_cnt++;
            chk("req", MemReq, 1);
            chk("wait_done", Done, 0);
            chk("addr", MemAddr, v.addr & 32'hFFFFFFFC);
            chk("we", MemWe, v.wr);
            chk("be", MemBe, v.be);
            if (v.wr) chk("wdata", MemWData, v.mwdata);
        end
        @(posedge clk); #1;
        MemAck = 0; MemRData = $urandom;
        @(negedge clk);
        chk("done", Done, 1);
        chk("stall_cycles", stall_cnt, k_end + 1);
        chk("done_stall", Stall, 0);
        chk("buserr", BusErr, v.berr);
        chk("rddata", RdData, v.rd_exp);
        chk("done_req", MemReq, 0);
        @(posedge clk); #1;
        MemRead = 0; MemWrite = 0;
        @(negedge clk);
        chk("no_reissue", MemReq, 0);
        chk("post_done", Done, 0);
        chk("post_buserr", BusErr, 0);
    endtask

    initial begin
        vec_t v;
        reset = 1; MemRead = 0; MemWrite = 0; Funct3 = 0; Addr = 0; WrData = 0;
        MemAck = 0; MemRData = 0;

        //         rd    wr    f3      addr        wdata         rdata         k   fault be     mwdata        rd_exp        berr
        tbl.push_back('{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1,  1'b0, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 3,  1'b0, 4'hF, 32'h0,        32'hFFFFFF80, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 2,  1'b0, 4'hF, 32'h0,        32'h00000080, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0,        2,  1'b0, 4'hC, 32'hABCDABCD, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        1,  1'b1, 4'hF, 32'h0,        32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h200, 32'h0,        32'h11111111, 99, 1'b0, 4'hF, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b1, 1'b1, 3'b010, 32'h040, 32'h12345678, 32'h55555555, 1,  1'b0, 4'hF, 32'h12345678, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b1, 3'b011, 32'h040, 32'h12345678, 32'h0,        1,  1'b1, 4'hF, 32'h0,        32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h80017FFF, 1,  1'b0, 4'hF, 32'h0,        32'h00008001, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 2,  1'b0, 4'hF, 32'h0,        32'hFFFF8001, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'b000, 32'h101, 32'h123456A5, 32'h0,        1,  1'b0, 4'h2, 32'hA5A5A5A5, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D, 4,  1'b0, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'b010, 32'h106, 32'h0,        32'h0,        1,  1'b1, 4'hF, 32'h0,        32'h0,        1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        1,  1'b1, 4'hF, 32'h0,        32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'b110, 32'h100, 32'h0,        32'h0,        1,  1'b1, 4'hF, 32'h0,        32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'b000, 32'h102, 32'h0,        32'h007F0000, 1,  1'b0, 4'hF, 32'h0,        32'h0000007F, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h1234FFFE, 3,  1'b0, 4'hF, 32'h0,        32'h0000FFFE, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000FF, 32'h0,        1,  1'b0, 4'h8, 32'hFFFFFFFF, 32'h0,        1'b0});

        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        cur_tag = "reset";
        chk("req", MemReq, 0);
        chk("we", MemWe, 0);
        chk("done", Done, 0);
        chk("fault", Fault, 0);
        chk("buserr", BusErr, 0);
        chk("stall", Stall, 0);
        chk("rddata", RdData, 0);
        chk("addr", MemAddr, 0);
        chk("wdata", MemWData, 0);
        chk("be", MemBe, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cur_tag = $sformatf("vec%0d", i);
            run_txn(tbl[i]);
        end

        cur_tag = "stray_ack";
        @(posedge clk); #1;
        MemAck = 1; MemRData = 32'hFFFFFFFF;
        @(negedge clk);
        @(posedge clk); #1;
        MemAck = 0;
        @(negedge clk);
        chk("done", Done, 0);
        chk("req", MemReq, 0);

        cur_tag = "reset_in_wait";
        @(posedge clk); #1;
        MemWrite = 1; Funct3 = 3'b010; Addr = 32'h300; WrData = 32'h0BADF00D;
        @(posedge clk); #1;
        @(negedge clk);
        chk("req_before", MemReq, 1);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0; MemWrite = 0;
        @(negedge clk);
        chk("req", MemReq, 0);
        chk("done", Done, 0);
        chk("buserr", BusErr, 0);
        chk("be", MemBe, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            MemAck = 1;
            @(negedge clk);
            chk("late_done", Done, 0);
            chk("late_buserr", BusErr, 0);
            chk("late_req", MemReq, 0);
        end
        MemAck = 0;
        cur_tag = "lw_after_reset";
        v = '{1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 32'h600DCAFE, 2, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0};
        run_txn(model(v));

        for (int i = 0; i < 150; i++) begin
            int sel;
            sel     = $urandom_range(1, 3);
            v.rd    = sel[0];
            v.wr    = sel[1];
            v.f3    = 3'($urandom_range(0, 7));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.ack_k = $urandom_range(1, TO + 2);
            cur_tag = $sformatf("rnd%0d", i);
            run_txn(model(v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-stage consumer of the decoded MemRead/MemWrite/Funct3 control. Turns each load/store into a req/ack transaction on the data-memory bus.
- Stalls the pipeline until the access completes.
- Performs byte-lane steering for stores and sign/zero extension for loads.
- Flags misaligned or unsupported accesses and bus timeouts.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width. Fixed at 32; four byte lanes.
- TIMEOUT, 16, maximum WAIT cycles without MemAck before BusErr. 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- MemRead  in  1  load in memory stage
- MemWrite  in  1  store in memory stage
- Funct3  in  3  access size/signedness (instr[14:12])
- Addr  in  ADDR_W  byte address from ALU
- WrData  in  DATA_W  store data (rs2)
- RdData  out  DATA_W  extended load result, valid when Done=1
- Done  out  1  access completes this cycle
- Stall  out  1  hold pipeline (PC, IF/ID, ID/EX, EX/MEM)
- Fault  out  1  one-cycle pulse: misaligned or unsupported Funct3
- BusErr  out  1  one-cycle pulse: timeout
- MemReq  out  1  bus request, held until MemAck
- MemWe  out  1  1 = write
- MemAddr  out  ADDR_W  word-aligned address (Addr with [1:0]=0)
- MemWData  out  DATA_W  lane-replicated store data
- MemBe  out  4  byte enables
- MemAck  in  1  bus completion, may arrive in the first MemReq cycle
- MemRData  in  DATA_W  read word, valid with MemAck

Behaviour:
- Reset: state IDLE, timeout counter 0. MemReq, MemWe, Done, Fault and BusErr are 0; RdData, MemAddr, MemWData and MemBe are 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - access = MemRead|MemWrite. If both are set, treat as a write.
  - Legal loads: Funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Legal stores: 000 sb, 001 sh, 010 sw.
  - Misaligned: halfword with Addr[0]=1, or word with Addr[1:0]!=0.
  - Illegal or misaligned access: Fault=1 for one cycle, no bus request, Stall=0, RdData=0, remain in IDLE.
  - Legal access: Stall=1 combinationally. Register MemAddr, MemWe, MemBe, MemWData and the load type. Go to WAIT; MemReq=1 from the next cycle.
- Store lanes:
  - sb: MemBe = 1<<Addr[1:0]; byte replicated to all lanes.
  - sh: MemBe = 0011 or 1100; halfword replicated to both halves.
  - sw: MemBe = 1111.
- Loads drive MemBe=1111.
- WAIT:
  - Stall=1; MemReq=1 with address, data and enables stable.
  - On MemAck: capture the extended MemRData into RdData (loads only; stores set RdData=0), drop MemReq next cycle, go to DONE.
  - Timeout counter increments each WAIT cycle without MemAck. When the count reaches TIMEOUT (ack absent in cycle TIMEOUT): BusErr pulse, RdData=0, go to DONE.
- DONE:
  - Done=1 and Stall=0 for exactly one cycle; the pipeline advances at this edge.
  - MemRead/MemWrite are ignored in DONE, so the same instruction is never reissued. Return to IDLE.
- Latency: access enters at cycle 0; MemReq rises at cycle 1; ack in cycle k≥1 gives Done at k+1. Minimum stall is 2 cycles.
- MemAck outside WAIT is ignored.
- Reset in WAIT: MemReq=0 from the cycle after the reset edge. The pending access is abandoned without Done or BusErr.
- Load extension by Addr[1:0] lane: lb/lh sign-extend, lbu/lhu zero-extend, lw passes through.

Decomposition:
- Shared package dmem_pkg:
  - Funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM enum {IDLE, WAIT, DONE}.
  - Byte-enable width constant.
- One combinational sub-module, load_extend (Funct3, byte offset, raw word → RdData), reused by the forwarding path.

Test Plan:
- sw Addr=0x100, WrData=0xDEADBEEF, ack at first MemReq cycle → MemBe=1111, MemAddr=0x100, Stall high 2 cycles, Done at cycle 2.
- lb Addr=0x103, MemRData=0x80FF_0000, ack after 3 WAIT cycles → RdData=0xFFFFFF80, Done at cycle 4. The same word with lbu → 0x00000080.
- sh Addr=0x102, WrData=0x0000ABCD → MemBe=1100, MemWData=0xABCDABCD. lh Addr=0x101 → Fault pulse, MemReq never asserted, Stall=0.
- lw with TIMEOUT=4 and MemAck never returned → MemReq high 4 cycles, BusErr and Done pulse together, RdData=0, then IDLE.
- Reset asserted during WAIT of a store → MemReq=0 the next cycle, no Done or BusErr. The next lw completes normally.
- MemRead and MemWrite both set, Funct3=010 → treated as a write (MemWe=1). Funct3=011 → Fault.
